if_fetch_gen: RTL and testbench



---
 rtl/if_fetch_gen.sv | 122 ++++++++++++
 tb/tb_if_fetch_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_gen.sv
// rtl/if_fetch_gen.sv - fetch-group PC generator with delay-slot FSM, request cap and epoch tag
module if_fetch_gen #(
  parameter int ADDR_W = 32,
  parameter int FETCH_WORDS = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC0_0000)
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   bp_if_en,
  input  logic [ADDR_W-1:0]      bp_if_target,
  input  logic                   bp_if_delot_en,
  input  logic [ADDR_W-1:0]      bp_if_delot_pc,
  input  logic                   ex_bp_error,
  input  logic [ADDR_W-1:0]      ex_new_target,
  input  logic                   exc_flush_all,
  input  logic [ADDR_W-1:0]      cp0_if_excaddr,
  output logic                   if_req_valid,
  input  logic                   if_req_ready,
  output logic [ADDR_W-1:0]      if_req_pc,
  output logic [FETCH_WORDS-1:0] if_req_mask,
  output logic                   if_req_delot,
  output logic                   if_req_epoch,
  input  logic                   icache_resp_valid,
  output logic [2:0]             if_outstanding
);

  typedef enum logic {SEQ = 1'b0, DSLOT = 1'b1} state_t;

  // Byte offset bits inside one aligned fetch group.
  localparam logic [ADDR_W-1:0] GRP_MASK  = ADDR_W'(FETCH_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] GRP_BYTES = ADDR_W'(FETCH_WORDS * 4);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] tgt, tgt_nxt;
  logic              epoch, epoch_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lane;
  logic              accept;
  logic              resp_dec;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  assign base         = pc & ~GRP_MASK;
  assign lane         = (pc & GRP_MASK) >> 2;
  assign if_req_valid = (cnt != 3'(MAX_OUTSTANDING));
  assign accept       = if_req_valid && if_req_ready;
  // A response with nothing in flight is spurious and must not underflow the count.
  assign resp_dec     = icache_resp_valid && (cnt != 3'd0);
  assign redirect     = exc_flush_all || ex_bp_error;
  assign redirect_pc  = exc_flush_all ? {cp0_if_excaddr[ADDR_W-1:2], 2'b00}
                                      : {ex_new_target[ADDR_W-1:2], 2'b00};

  assign if_req_pc      = pc;
  assign if_req_delot   = (state == DSLOT);
  assign if_req_epoch   = epoch;
  assign if_outstanding = cnt;

  // Lane mask: tail of the group from the entry lane, or the single delay-slot lane.
  always_comb begin
    if_req_mask = '0;
    for (int i = 0; i < FETCH_WORDS; i++) begin
      if (state == DSLOT) if_req_mask[i] = (lane == ADDR_W'(i));
      else                if_req_mask[i] = (lane <= ADDR_W'(i));
    end
  end

  // State, PC, latched target, epoch and in-flight count registers.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state <= SEQ;
      pc    <= RESET_VECTOR;
      tgt   <= '0;
      epoch <= 1'b0;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      tgt   <= tgt_nxt;
      epoch <= epoch_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: redirects win over everything; otherwise advance only on accept.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt;
    epoch_nxt = epoch;
    cnt_nxt   = cnt + {2'b00, accept} - {2'b00, resp_dec};
    if (redirect) begin
      pc_nxt    = redirect_pc;
      state_nxt = SEQ;
      tgt_nxt   = '0;
      epoch_nxt = ~epoch;
    end else if (accept) begin
      case (state)
        SEQ: begin
          if (bp_if_en && bp_if_delot_en) begin
            pc_nxt    = bp_if_delot_pc;
            tgt_nxt   = bp_if_target;
            state_nxt = DSLOT;
          end else if (bp_if_en) begin
            pc_nxt = bp_if_target;
          end else begin
            pc_nxt = base + GRP_BYTES;
          end
        end
        DSLOT: begin
          pc_nxt    = tgt;
          tgt_nxt   = '0;
          state_nxt = SEQ;
        end
        default: state_nxt = SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_gen.sv
// tb/tb_if_fetch_gen.sv - self-checking bench for if_fetch_gen
module tb_if_fetch_gen;
  localparam int FW = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic clk = 0;
  logic rst_;
  logic bp_if_en, bp_if_delot_en, ex_bp_error, exc_flush_all;
  logic [31:0] bp_if_target, bp_if_delot_pc, ex_new_target, cp0_if_excaddr;
  logic if_req_valid, if_req_ready, if_req_delot, if_req_epoch, icache_resp_valid;
  logic [31:0] if_req_pc;
  logic [FW-1:0] if_req_mask;
  logic [2:0] if_outstanding;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_ds;
  logic [31:0] m_tgt;
  bit          m_ep;
  int          m_cnt;

  if_fetch_gen #(.ADDR_W(32), .FETCH_WORDS(FW), .MAX_OUTSTANDING(MAXO), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_(rst_),
    .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target),
    .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_pc(if_req_pc), .if_req_mask(if_req_mask),
    .if_req_delot(if_req_delot), .if_req_epoch(if_req_epoch),
    .icache_resp_valid(icache_resp_valid), .if_outstanding(if_outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] exp_mask(input logic [31:0] pc, input bit ds);
    int l;
    logic [FW-1:0] m;
    l = int'((pc / 4) % FW);
    for (int i = 0; i < FW; i++) m[i] = ds ? (i == l) : (i >= l);
    return m;
  endfunction

  // Advance the reference model by one cycle from the inputs seen at the edge.
  task automatic model_update();
    bit acc;
    bit dec;
    acc = (m_cnt != MAXO) && if_req_ready;
    dec = icache_resp_valid && (m_cnt > 0);
    if (rst_) begin
      m_pc = RV; m_ds = 0; m_tgt = 0; m_ep = 0; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + int'(acc) - int'(dec);
      if (exc_flush_all || ex_bp_error) begin
        m_pc  = (exc_flush_all ? cp0_if_excaddr : ex_new_target) & ~32'd3;
        m_ds  = 0;
        m_tgt = 0;
        m_ep  = !m_ep;
      end else if (acc) begin
        if (m_ds) begin
          m_pc = m_tgt; m_ds = 0;
        end else if (bp_if_en && bp_if_delot_en) begin
          m_pc = bp_if_delot_pc; m_tgt = bp_if_target; m_ds = 1;
        end else if (bp_if_en) begin
          m_pc = bp_if_target;
        end else begin
          m_pc = m_pc - (m_pc % (FW * 4)) + FW * 4;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_redirects();
    bp_if_en = 0; bp_if_delot_en = 0; ex_bp_error = 0; exc_flush_all = 0;
  endtask

  task automatic test_reset();
    rst_ = 1; if_req_ready = 1; icache_resp_valid = 1;
    clear_redirects();
    bp_if_target = 0; bp_if_delot_pc = 0; ex_new_target = 0; cp0_if_excaddr = 0;
    tick(); tick();
    rst_ = 0;
    checks++; if (if_req_pc !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc got %h exp BFC00000", if_req_pc); end
    checks++; if (if_req_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b exp 1", if_req_valid); end
    checks++; if (if_req_mask !== 4'b1111) begin errors++; $display("FAIL reset_mask got %b exp 1111", if_req_mask); end
    checks++; if (if_req_epoch !== 1'b0 || if_req_delot !== 1'b0) begin errors++; $display("FAIL reset_epoch_delot got %b%b exp 00", if_req_epoch, if_req_delot); end
    checks++; if (if_outstanding !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", if_outstanding); end
    tick();
    checks++; if (if_req_pc !== 32'hBFC00010) begin errors++; $display("FAIL seq_pc1 got %h exp BFC00010", if_req_pc); end
    tick();
    checks++; if (if_req_pc !== 32'hBFC00020) begin errors++; $display("FAIL seq_pc2 got %h exp BFC00020", if_req_pc); end
    checks++; if (if_outstanding !== 3'd1) begin errors++; $display("FAIL seq_cnt got %0d exp 1", if_outstanding); end
  endtask

  task automatic test_redirect();
    ex_bp_error = 1; ex_new_target = 32'h80000008;
    tick();
    clear_redirects();
    checks++; if (if_req_pc !== 32'h80000008) begin errors++; $display("FAIL redir_pc got %h exp 80000008", if_req_pc); end
    checks++; if (if_req_mask !== 4'b1100) begin errors++; $display("FAIL redir_mask got %b exp 1100", if_req_mask); end
    checks++; if (if_req_epoch !== 1'b1) begin errors++; $display("FAIL redir_epoch got %b exp 1", if_req_epoch); end
    tick();
    checks++; if (if_req_pc !== 32'h80000010 || if_req_mask !== 4'b1111) begin errors++; $display("FAIL redir_next got %h/%b exp 80000010/1111", if_req_pc, if_req_mask); end
  endtask

  task automatic test_dslot();
    bp_if_en = 1; bp_if_delot_en = 1; bp_if_delot_pc = 32'h80000020; bp_if_target = 32'h80000100;
    tick();
    clear_redirects();
    checks++; if (if_req_pc !== 32'h80000020) begin errors++; $display("FAIL dslot_pc got %h exp 80000020", if_req_pc); end
    checks++; if (if_req_delot !== 1'b1 || if_req_mask !== 4'b0001) begin errors++; $display("FAIL dslot_req got %b/%b exp 1/0001", if_req_delot, if_req_mask); end
    tick();
    checks++; if (if_req_pc !== 32'h80000100 || if_req_mask !== 4'b1111 || if_req_delot !== 1'b0) begin errors++; $display("FAIL dslot_tgt got %h/%b/%b exp 80000100/1111/0", if_req_pc, if_req_mask, if_req_delot); end
  endtask

  task automatic test_outstanding();
    if_req_ready = 0; icache_resp_valid = 1;
    tick(); tick(); tick();
    checks++; if (if_outstanding !== 3'd0) begin errors++; $display("FAIL drain_cnt got %0d exp 0", if_outstanding); end
    if_req_ready = 1; icache_resp_valid = 0;
    tick();
    checks++; if (if_outstanding !== 3'd1 || if_req_valid !== 1'b1) begin errors++; $display("FAIL cap_one got %0d/%b exp 1/1", if_outstanding, if_req_valid); end
    tick();
    checks++; if (if_outstanding !== 3'd2 || if_req_valid !== 1'b0) begin errors++; $display("FAIL cap_full got %0d/%b exp 2/0", if_outstanding, if_req_valid); end
    tick(); tick();
    checks++; if (if_req_pc !== 32'h80000120) begin errors++; $display("FAIL cap_hold got %h exp 80000120", if_req_pc); end
    icache_resp_valid = 1;
    tick();
    checks++; if (if_req_valid !== 1'b1 || if_outstanding !== 3'd1 || if_req_pc !== 32'h80000120) begin errors++; $display("FAIL cap_release got %b/%0d/%h exp 1/1/80000120", if_req_valid, if_outstanding, if_req_pc); end
  endtask

  task automatic test_flush();
    exc_flush_all = 1; cp0_if_excaddr = 32'h12345677; ex_bp_error = 1; ex_new_target = 32'h55555550;
    tick();
    clear_redirects();
    checks++; if (if_req_pc !== 32'h12345674 || if_req_epoch !== 1'b0) begin errors++; $display("FAIL flush_prio got %h/%b exp 12345674/0", if_req_pc, if_req_epoch); end
    checks++; if (if_req_mask !== 4'b1110) begin errors++; $display("FAIL flush_mask got %b exp 1110", if_req_mask); end
    bp_if_en = 1; bp_if_delot_en = 1; bp_if_delot_pc = 32'h12345680; bp_if_target = 32'h0BAD0000;
    tick();
    clear_redirects();
    checks++; if (if_req_delot !== 1'b1 || if_req_pc !== 32'h12345680) begin errors++; $display("FAIL flush_dslot_entry got %b/%h exp 1/12345680", if_req_delot, if_req_pc); end
    if_req_ready = 0; exc_flush_all = 1; cp0_if_excaddr = 32'h00400000;
    tick();
    clear_redirects();
    checks++; if (if_req_pc !== 32'h00400000 || if_req_delot !== 1'b0 || if_req_epoch !== 1'b1) begin errors++; $display("FAIL flush_in_dslot got %h/%b/%b exp 00400000/0/1", if_req_pc, if_req_delot, if_req_epoch); end
    if_req_ready = 1;
    tick();
    checks++; if (if_req_pc !== 32'h00400010) begin errors++; $display("FAIL flush_drop_tgt got %h exp 00400010", if_req_pc); end
  endtask

  task automatic test_wrap_and_reset();
    ex_bp_error = 1; ex_new_target = 32'hFFFFFFF0;
    tick();
    clear_redirects();
    checks++; if (if_req_pc !== 32'hFFFFFFF0) begin errors++; $display("FAIL wrap_setup got %h exp FFFFFFF0", if_req_pc); end
    tick();
    checks++; if (if_req_pc !== 32'h00000000) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", if_req_pc); end
    icache_resp_valid = 0;
    tick(); tick(); tick();
    checks++; if (if_outstanding !== 3'd2) begin errors++; $display("FAIL prerst_cnt got %0d exp 2", if_outstanding); end
    rst_ = 1;
    tick();
    rst_ = 0;
    checks++; if (if_outstanding !== 3'd0 || if_req_pc !== RV || if_req_epoch !== 1'b0) begin errors++; $display("FAIL midrst got %0d/%h/%b exp 0/%h/0", if_outstanding, if_req_pc, if_req_epoch, RV); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_              = ($urandom_range(0, 99) == 0);
      if_req_ready      = ($urandom_range(0, 3) != 0);
      icache_resp_valid = ($urandom_range(0, 1) == 1);
      bp_if_en          = ($urandom_range(0, 2) == 0);
      bp_if_delot_en    = ($urandom_range(0, 1) == 1);
      bp_if_target      = $urandom & ~32'd3;
      bp_if_delot_pc    = $urandom & ~32'd3;
      ex_bp_error       = ($urandom_range(0, 15) == 0);
      exc_flush_all     = ($urandom_range(0, 19) == 0);
      ex_new_target     = $urandom;
      cp0_if_excaddr    = $urandom;
      tick();
      checks++;
      if (if_req_pc !== m_pc || if_req_mask !== exp_mask(m_pc, m_ds) || if_req_delot !== m_ds ||
          if_req_epoch !== m_ep || if_outstanding !== 3'(m_cnt) || if_req_valid !== (m_cnt != MAXO)) begin
        errors++;
        $display("FAIL rand[%0d] got pc=%h m=%b d=%b e=%b c=%0d v=%b exp pc=%h m=%b d=%b e=%b c=%0d v=%b",
                 n, if_req_pc, if_req_mask, if_req_delot, if_req_epoch, if_outstanding, if_req_valid,
                 m_pc, exp_mask(m_pc, m_ds), m_ds, m_ep, m_cnt, (m_cnt != MAXO));
      end
    end
    rst_ = 0;
  endtask

  initial begin
    m_pc = RV; m_ds = 0; m_tgt = 0; m_ep = 0; m_cnt = 0;
    test_reset();
    test_redirect();
    test_dslot();
    test_outstanding();
    test_flush();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
